// File: rtl/icg_multi_hyst.sv
// Multi-channel clock gate with per-channel hysteresis.
// Each channel keeps its clock running for HOLD cycles after its request
// drops, can be forced off, and is forced on by TE. Gating uses a
// low-transparent latch so Q never glitches or truncates a high phase.
module icg_multi_hyst #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned HOLD = 8,
  parameter int unsigned CW   = 4
) (
  input  logic           CLK,
  input  logic           RN,
  input  logic [NCH-1:0] E,
  input  logic [NCH-1:0] FO,
  input  logic           TE,
  output logic [NCH-1:0] Q,
  output logic [NCH-1:0] ACTIVE,
  output logic           BUSY
);

  // Reject configurations the counter or channel vector cannot represent.
  if (HOLD > (2 ** CW) - 1) begin : g_bad_hold
    $error("icg_multi_hyst: HOLD does not fit in CW bits");
  end
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("icg_multi_hyst: NCH must be 1..32");
  end

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StOn   = 2'd1,
    StHold = 2'd2
  } state_e;

  // Counter reload on request drop; counting HoldLoad..0 spans HOLD cycles.
  localparam logic [CW-1:0] HoldLoad = (HOLD == 0) ? '0 : CW'(HOLD - 1);

  state_e         state_q [NCH];
  state_e         state_d [NCH];
  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [NCH-1:0] en_q;
  logic [NCH-1:0] en_d;
  logic [NCH-1:0] lat_d;
  logic [NCH-1:0] lat_q;

  // State register: FSM state, hold counter and registered enable.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
      en_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q <= en_d;
    end
  end

  // Next-state logic, one independent FSM per channel; force-off wins.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (FO[i]) begin
        state_d[i] = StOff;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          StOff: begin
            if (E[i]) begin
              state_d[i] = StOn;
              cnt_d[i]   = '0;
            end
          end
          StOn: begin
            if (!E[i]) begin
              state_d[i] = (HOLD == 0) ? StOff : StHold;
              cnt_d[i]   = HoldLoad;
            end
          end
          StHold: begin
            if (E[i]) begin
              // Re-request beats expiry in the same cycle.
              state_d[i] = StOn;
              cnt_d[i]   = '0;
            end else if (cnt_q[i] == '0) begin
              state_d[i] = StOff;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
          default: begin
            state_d[i] = StOff;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Output decode: enable for the next cycle and latch input with test override.
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NCH; i++) begin
      en_d[i] = (state_d[i] != StOff);
    end
    lat_d = en_q | {NCH{TE}};
  end

  // Gating latch: transparent in the low phase so Q only sees clean high phases.
  always_latch begin
    if (!CLK) begin
      lat_q <= lat_d;
    end
  end

  assign Q      = {NCH{CLK}} & lat_q;
  assign ACTIVE = en_q;
  assign BUSY   = |en_q;

endmodule

// File: tb/tb_icg_multi_hyst.sv
// Bench for icg_multi_hyst: two instances (HOLD=3 and HOLD=0) driven by the
// same inputs and compared against an age-based reference model.
module tb_icg_multi_hyst;
  localparam int unsigned NCH = 4;
  localparam int          INF = 1000;

  logic           CLK = 1'b0;
  logic           RN;
  logic           TE;
  logic [NCH-1:0] E;
  logic [NCH-1:0] FO;
  logic [NCH-1:0] q3, a3, q0, a0;
  logic           b3, b0;

  int errors = 0;
  int checks = 0;
  // Edges since the request was last seen high (INF after reset/force-off).
  int age [NCH];
  bit qvalid = 1'b0;

  always #5 CLK = ~CLK;

  icg_multi_hyst #(.NCH(NCH), .HOLD(3), .CW(4)) dut3 (
    .CLK(CLK), .RN(RN), .E(E), .FO(FO), .TE(TE), .Q(q3), .ACTIVE(a3), .BUSY(b3)
  );

  icg_multi_hyst #(.NCH(NCH), .HOLD(0), .CW(4)) dut0 (
    .CLK(CLK), .RN(RN), .E(E), .FO(FO), .TE(TE), .Q(q0), .ACTIVE(a0), .BUSY(b0)
  );

  // A channel is active while the request is high or was high within h edges.
  function automatic logic [NCH-1:0] act(int h);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (age[i] <= h);
    return r;
  endfunction

  task automatic chk(string tag, logic [NCH-1:0] got, logic [NCH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // One clock cycle: low-phase Q check, edge, model update, high-phase checks.
  task automatic cycle();
    logic [NCH-1:0] e3, e0;
    if (CLK) @(negedge CLK);
    #1;
    chk("q3_low", q3, '0);
    chk("q0_low", q0, '0);
    e3 = act(3) | {NCH{TE}};
    e0 = act(0) | {NCH{TE}};
    @(posedge CLK);
    for (int i = 0; i < NCH; i++) begin
      if (!RN || FO[i])     age[i] = INF;
      else if (E[i])        age[i] = 0;
      else if (age[i] < INF) age[i] = age[i] + 1;
    end
    #1;
    if (qvalid) begin
      chk("q3_high", q3, e3);
      chk("q0_high", q0, e0);
    end
    qvalid = 1'b1;
    chk("active3", a3, act(3));
    chk("active0", a0, act(0));
    chk("busy3", {3'b000, b3}, {3'b000, |act(3)});
    chk("busy0", {3'b000, b0}, {3'b000, |act(0)});
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  // Every Q high pulse must last exactly one CLK high phase.
  logic [2*NCH-1:0] qq;
  logic [2*NCH-1:0] ql = '0;
  time              rise [2*NCH];
  assign qq = {q3, q0};

  always @(qq) begin
    for (int i = 0; i < 2 * NCH; i++) begin
      if (qq[i] && !ql[i]) begin
        rise[i] = $time;
      end else if (!qq[i] && ql[i]) begin
        checks++;
        assert ($time - rise[i] == 5) else begin
          errors++;
          $error("FAIL q_pulse_width bit=%0d got=%0t exp=5", i, $time - rise[i]);
        end
      end
    end
    ql = qq;
  end

  initial begin
    for (int i = 0; i < NCH; i++) age[i] = INF;
    RN = 1'b0; TE = 1'b0; E = '0; FO = '0;
    run(3);
    RN = 1'b1;
    run(2);

    // Request held for 11 edges then dropped: hold tail then off.
    E[0] = 1'b1; run(11);
    E[0] = 1'b0; run(6);

    // Drop and re-request inside the hold window, then a clean drop.
    E[1] = 1'b1; run(3);
    E[1] = 1'b0; run(2);
    E[1] = 1'b1; run(2);
    E[1] = 1'b0; run(6);

    // Force-off pulse while requested; restart after FO clears.
    E[2] = 1'b1; run(3);
    FO[2] = 1'b1; run(1);
    FO[2] = 1'b0; E[2] = 1'b0; run(1);
    E[2] = 1'b1; run(3);
    E[2] = 1'b0; run(5);

    // Test enable with no requests.
    TE = 1'b1; run(3);
    TE = 1'b0; run(3);

    // Reset while channels are on or holding.
    E = 4'hf; run(4);
    E = 4'h3; run(1);
    RN = 1'b0; run(1);
    RN = 1'b1; E = '0; run(4);

    // Random traffic with sticky requests and sparse force/test/reset.
    for (int n = 0; n < 400; n++) begin
      E  = E ^ NCH'($urandom & $urandom);
      FO = NCH'($urandom & $urandom & $urandom);
      TE = ($urandom_range(15) == 0);
      RN = ($urandom_range(39) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
